// File: rtl/rv32_bus_arbiter_if.sv
// External bus master port of the RV32 bus arbiter: level request/grant
// handshake, one transaction per cycle, single-cycle read response.
interface rv32_bus_arbiter_if #(
    parameter int address_width = 32,
    parameter int data_width    = 32
);
    logic                     ext_req_i;
    logic                     ext_gnt_o;
    logic                     ext_valid_i;
    logic                     ext_we_i;
    logic [3:0]               ext_be_i;
    logic [address_width-1:0] ext_address_i;
    logic [data_width-1:0]    ext_wdata_i;
    logic [data_width-1:0]    ext_rdata_o;
    logic                     ext_rvalid_o;
    logic                     ext_timeout_o;

    modport slave (
        input  ext_req_i, ext_valid_i, ext_we_i, ext_be_i, ext_address_i, ext_wdata_i,
        output ext_gnt_o, ext_rdata_o, ext_rvalid_o, ext_timeout_o
    );

    modport master (
        output ext_req_i, ext_valid_i, ext_we_i, ext_be_i, ext_address_i, ext_wdata_i,
        input  ext_gnt_o, ext_rdata_o, ext_rvalid_o, ext_timeout_o
    );
endinterface

// File: rtl/rv32_bus_arbiter.sv
// Shares the RV32 CPU bus with one external master: halts the CPU, grants the
// bus, then replays the CPU's held address for one cycle before unhalting.
module rv32_bus_arbiter #(
    parameter int address_width    = 32,
    parameter int data_width       = 32,
    parameter int HaltSettleCycles = 2,
    parameter int MaxGrantCycles   = 256,
    parameter int CpuMinCycles     = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [address_width-1:0] cpu_address_i,
    input  logic [data_width-1:0]    cpu_data_i,
    input  logic                     cpu_we_i,
    input  logic [3:0]               cpu_we_ram_i,
    input  logic                     cpu_halt_i,
    output logic                     cpu_halt_o,
    rv32_bus_arbiter_if.slave        ext,
    output logic [address_width-1:0] bus_address_o,
    output logic [data_width-1:0]    bus_data_o,
    output logic                     bus_we_o,
    output logic [3:0]               bus_we_ram_o,
    input  logic [data_width-1:0]    bus_rdata_i
);
    localparam int GW = (MaxGrantCycles > 1) ? $clog2(MaxGrantCycles + 1) : 1;
    localparam int CW = (CpuMinCycles > 1) ? $clog2(CpuMinCycles + 1) : 1;
    localparam logic [GW-1:0] GLAST = (MaxGrantCycles > 0) ? GW'(MaxGrantCycles - 1) : '0;
    localparam logic [CW-1:0] CMIN  = CW'(CpuMinCycles);
    localparam logic [3:0]    HLAST = 4'(HaltSettleCycles - 1);
    localparam bit            TIMEOUT_EN = (MaxGrantCycles > 0);

    typedef enum logic [1:0] {
        S_CPU_OWN,
        S_HALT_WAIT,
        S_EXT_OWN,
        S_RESTORE
    } state_t;

    state_t                   r_state;
    logic [3:0]               r_hcnt;
    logic [GW-1:0]            r_gcnt;
    logic [CW-1:0]            r_cool;
    logic                     r_rd_pend;
    logic                     r_timeout;
    logic [address_width-1:0] r_hold_addr;
    logic [data_width-1:0]    r_hold_data;

    logic w_cool_done;
    logic w_ext_acc;
    logic w_ext_rd;
    logic w_timeout;

    assign w_cool_done = (r_cool >= CMIN);
    assign w_ext_acc   = (r_state == S_EXT_OWN) && ext.ext_valid_i;
    assign w_ext_rd    = w_ext_acc && !ext.ext_we_i;
    assign w_timeout   = TIMEOUT_EN && (r_gcnt == GLAST);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= S_CPU_OWN;
            r_hcnt    <= '0;
            r_gcnt    <= '0;
            r_cool    <= CMIN;
            r_rd_pend <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_rd_pend <= w_ext_rd;
            r_timeout <= 1'b0;
            case (r_state)
                S_CPU_OWN: begin
                    if (!w_cool_done) r_cool <= r_cool + CW'(1);
                    if (ext.ext_req_i && w_cool_done) begin
                        r_state <= S_HALT_WAIT;
                        r_hcnt  <= '0;
                    end
                end
                S_HALT_WAIT: begin
                    r_hcnt <= r_hcnt + 4'd1;
                    if (!ext.ext_req_i) begin
                        r_state <= S_RESTORE;
                    end else if (r_hcnt == HLAST) begin
                        r_state <= S_EXT_OWN;
                        r_gcnt  <= '0;
                    end
                end
                S_EXT_OWN: begin
                    r_gcnt <= r_gcnt + GW'(1);
                    // A voluntary release in the timeout cycle suppresses the pulse.
                    if (!ext.ext_req_i) begin
                        r_state <= S_RESTORE;
                    end else if (w_timeout) begin
                        r_state   <= S_RESTORE;
                        r_timeout <= 1'b1;
                    end
                end
                S_RESTORE: begin
                    r_state <= S_CPU_OWN;
                    r_cool  <= '0;
                end
                default: r_state <= S_CPU_OWN;
            endcase
        end
    end

    // Idle bus value during the grant; seeded with the CPU's held transaction.
    always_ff @(posedge clk_i) begin
        if (r_state == S_HALT_WAIT) begin
            r_hold_addr <= cpu_address_i;
            r_hold_data <= cpu_data_i;
        end else if (w_ext_acc) begin
            r_hold_addr <= ext.ext_address_i;
            r_hold_data <= ext.ext_wdata_i;
        end
    end

    always_comb begin
        bus_address_o = cpu_address_i;
        bus_data_o    = cpu_data_i;
        bus_we_o      = cpu_we_i;
        bus_we_ram_o  = cpu_we_ram_i;
        cpu_halt_o    = cpu_halt_i;
        ext.ext_gnt_o = 1'b0;
        case (r_state)
            S_HALT_WAIT, S_RESTORE: begin
                cpu_halt_o   = 1'b1;
                bus_we_o     = 1'b0;
                bus_we_ram_o = 4'h0;
            end
            S_EXT_OWN: begin
                cpu_halt_o    = 1'b1;
                ext.ext_gnt_o = 1'b1;
                if (ext.ext_valid_i) begin
                    bus_address_o = ext.ext_address_i;
                    bus_data_o    = ext.ext_wdata_i;
                    bus_we_o      = ext.ext_we_i;
                    bus_we_ram_o  = ext.ext_we_i ? ext.ext_be_i : 4'h0;
                end else begin
                    bus_address_o = r_hold_addr;
                    bus_data_o    = r_hold_data;
                    bus_we_o      = 1'b0;
                    bus_we_ram_o  = 4'h0;
                end
            end
            default: ;
        endcase
    end

    assign ext.ext_rvalid_o  = r_rd_pend;
    assign ext.ext_rdata_o   = bus_rdata_i;
    assign ext.ext_timeout_o = r_timeout;
endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Directed bench for rv32_bus_arbiter with a small byte-enabled RAM whose read
// data follows a registered address, as the CPU bus decode does.
module tb_rv32_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] cpu_address_i;
    logic [31:0] cpu_data_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_we_ram_i;
    logic        cpu_halt_i;
    logic        cpu_halt_o;
    logic [31:0] bus_address_o;
    logic [31:0] bus_data_o;
    logic        bus_we_o;
    logic [3:0]  bus_we_ram_o;
    logic [31:0] bus_rdata_i;

    int n_chk  = 0;
    int n_fail = 0;

    rv32_bus_arbiter_if #(.address_width(32), .data_width(32)) u_if ();

    rv32_bus_arbiter #(
        .address_width(32), .data_width(32), .HaltSettleCycles(2),
        .MaxGrantCycles(8), .CpuMinCycles(16)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .cpu_address_i(cpu_address_i), .cpu_data_i(cpu_data_i),
        .cpu_we_i(cpu_we_i), .cpu_we_ram_i(cpu_we_ram_i),
        .cpu_halt_i(cpu_halt_i), .cpu_halt_o(cpu_halt_o),
        .ext(u_if),
        .bus_address_o(bus_address_o), .bus_data_o(bus_data_o),
        .bus_we_o(bus_we_o), .bus_we_ram_o(bus_we_ram_o),
        .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    logic [31:0] rd_addr = 32'h0;
    assign bus_rdata_i = mem[rd_addr[9:2]];

    always @(posedge clk) begin
        rd_addr <= bus_address_o;
        for (int b = 0; b < 4; b++)
            if (bus_we_ram_o[b]) mem[bus_address_o[9:2]][8*b +: 8] <= bus_data_o[8*b +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int budget);
        for (int i = 0; i < budget; i++) begin
            next_cycle();
            #1;
            if (u_if.ext_gnt_o) break;
        end
        chk("gnt_wait", {31'b0, u_if.ext_gnt_o}, 32'd1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        reset_i = 1'b1;
        cpu_address_i = 32'h0; cpu_data_i = 32'h0; cpu_we_i = 1'b0; cpu_we_ram_i = 4'h0;
        cpu_halt_i = 1'b0;
        u_if.ext_req_i = 1'b0; u_if.ext_valid_i = 1'b0; u_if.ext_we_i = 1'b0;
        u_if.ext_be_i = 4'h0; u_if.ext_address_i = 32'h0; u_if.ext_wdata_i = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 cpu_halt_i = 1'b1;
        #1;
        chk("rst_halt1", {31'b0, cpu_halt_o}, 32'd1);
        chk("rst_gnt", {31'b0, u_if.ext_gnt_o}, 32'd0);
        chk("rst_rvalid", {31'b0, u_if.ext_rvalid_o}, 32'd0);
        chk("rst_timeout", {31'b0, u_if.ext_timeout_o}, 32'd0);
        cpu_halt_i = 1'b0;
        #1 chk("rst_halt0", {31'b0, cpu_halt_o}, 32'd0);
        reset_i = 1'b0;

        // Idle pass-through
        next_cycle();
        cpu_address_i = 32'h100; cpu_data_i = 32'h12345678; cpu_we_i = 1'b1; cpu_we_ram_i = 4'hF;
        #1;
        chk("idle_addr", bus_address_o, 32'h100);
        chk("idle_data", bus_data_o, 32'h12345678);
        chk("idle_we", {31'b0, bus_we_o}, 32'd1);
        chk("idle_weram", {28'b0, bus_we_ram_o}, 32'hF);
        chk("idle_gnt", {31'b0, u_if.ext_gnt_o}, 32'd0);
        cpu_halt_i = 1'b1;
        #1 chk("idle_halt_follow", {31'b0, cpu_halt_o}, 32'd1);
        cpu_halt_i = 1'b0;

        // Grant sequence: request in cycle 0
        next_cycle();
        cpu_address_i = 32'h300; cpu_data_i = 32'h0; u_if.ext_req_i = 1'b1;
        #1;
        chk("c0_halt", {31'b0, cpu_halt_o}, 32'd0);
        chk("c0_gnt", {31'b0, u_if.ext_gnt_o}, 32'd0);
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            #1;
            chk("hw_halt", {31'b0, cpu_halt_o}, 32'd1);
            chk("hw_gnt", {31'b0, u_if.ext_gnt_o}, 32'd0);
            chk("hw_weram", {28'b0, bus_we_ram_o}, 32'h0);
            chk("hw_we", {31'b0, bus_we_o}, 32'd0);
            chk("hw_addr", bus_address_o, 32'h300);
        end

        // External write then read
        next_cycle();
        u_if.ext_valid_i = 1'b1; u_if.ext_we_i = 1'b1; u_if.ext_be_i = 4'hF;
        u_if.ext_address_i = 32'h200; u_if.ext_wdata_i = 32'hDEADBEEF;
        #1;
        chk("c3_gnt", {31'b0, u_if.ext_gnt_o}, 32'd1);
        chk("wr_addr", bus_address_o, 32'h200);
        chk("wr_data", bus_data_o, 32'hDEADBEEF);
        chk("wr_we", {31'b0, bus_we_o}, 32'd1);
        chk("wr_weram", {28'b0, bus_we_ram_o}, 32'hF);
        next_cycle();
        u_if.ext_we_i = 1'b0;
        #1;
        chk("rd_weram", {28'b0, bus_we_ram_o}, 32'h0);
        chk("rd_we", {31'b0, bus_we_o}, 32'd0);
        chk("rd_addr", bus_address_o, 32'h200);
        chk("wr_no_rvalid", {31'b0, u_if.ext_rvalid_o}, 32'd0);
        next_cycle();
        u_if.ext_valid_i = 1'b0;
        #1;
        chk("rd_rvalid", {31'b0, u_if.ext_rvalid_o}, 32'd1);
        chk("rd_rdata", u_if.ext_rdata_o, 32'hDEADBEEF);
        chk("idle_hold_addr", bus_address_o, 32'h200);
        chk("idle_hold_weram", {28'b0, bus_we_ram_o}, 32'h0);

        // Release with a read in the last granted cycle
        next_cycle();
        u_if.ext_req_i = 1'b0; u_if.ext_valid_i = 1'b1; u_if.ext_address_i = 32'h100;
        #1 chk("last_gnt", {31'b0, u_if.ext_gnt_o}, 32'd1);
        next_cycle();
        u_if.ext_valid_i = 1'b0;
        #1;
        chk("rs_gnt", {31'b0, u_if.ext_gnt_o}, 32'd0);
        chk("rs_halt", {31'b0, cpu_halt_o}, 32'd1);
        chk("rs_addr", bus_address_o, 32'h300);
        chk("rs_weram", {28'b0, bus_we_ram_o}, 32'h0);
        chk("rs_rvalid", {31'b0, u_if.ext_rvalid_o}, 32'd1);
        chk("rs_rdata", u_if.ext_rdata_o, 32'h12345678);
        chk("rs_timeout", {31'b0, u_if.ext_timeout_o}, 32'd0);

        // Re-request immediately: cooldown holds it off
        next_cycle();
        u_if.ext_req_i = 1'b1;
        #1;
        chk("cpu_halt", {31'b0, cpu_halt_o}, 32'd0);
        chk("cpu_rvalid", {31'b0, u_if.ext_rvalid_o}, 32'd0);
        chk("cpu_weram", {28'b0, bus_we_ram_o}, 32'hF);
        for (int c = 1; c <= 16; c++) begin
            next_cycle();
            #1;
            chk("cool_halt", {31'b0, cpu_halt_o}, 32'd0);
            chk("cool_gnt", {31'b0, u_if.ext_gnt_o}, 32'd0);
        end
        next_cycle();
        #1 chk("cool_expired_halt", {31'b0, cpu_halt_o}, 32'd1);

        // Timeout after 8 granted cycles with request held
        next_cycle();
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            #1;
            chk("to_gnt", {31'b0, u_if.ext_gnt_o}, 32'd1);
            chk("to_nopulse", {31'b0, u_if.ext_timeout_o}, 32'd0);
        end
        next_cycle();
        #1;
        chk("to_pulse", {31'b0, u_if.ext_timeout_o}, 32'd1);
        chk("to_gnt_drop", {31'b0, u_if.ext_gnt_o}, 32'd0);
        chk("to_halt", {31'b0, cpu_halt_o}, 32'd1);

        // CPU resumes; ungranted external traffic is ignored
        next_cycle();
        u_if.ext_valid_i = 1'b1; u_if.ext_we_i = 1'b1; u_if.ext_be_i = 4'hF;
        u_if.ext_address_i = 32'h200; u_if.ext_wdata_i = 32'h00000BAD;
        #1;
        chk("to_pulse_once", {31'b0, u_if.ext_timeout_o}, 32'd0);
        chk("resume_halt", {31'b0, cpu_halt_o}, 32'd0);
        chk("ign_addr", bus_address_o, 32'h300);
        chk("ign_data", bus_data_o, 32'h0);
        next_cycle();
        u_if.ext_we_i = 1'b0;
        next_cycle();
        u_if.ext_valid_i = 1'b0;
        #1 chk("ign_rvalid", {31'b0, u_if.ext_rvalid_o}, 32'd0);

        // Request drop in the timeout cycle: drop wins
        wait_gnt(40);
        repeat (6) next_cycle();
        next_cycle();
        u_if.ext_req_i = 1'b0;
        #1 chk("drop_gnt", {31'b0, u_if.ext_gnt_o}, 32'd1);
        next_cycle();
        #1;
        chk("drop_nopulse", {31'b0, u_if.ext_timeout_o}, 32'd0);
        chk("drop_gnt_low", {31'b0, u_if.ext_gnt_o}, 32'd0);

        // Reset mid-grant with a read accepted
        next_cycle();
        u_if.ext_req_i = 1'b1;
        wait_gnt(40);
        u_if.ext_valid_i = 1'b1; u_if.ext_we_i = 1'b0; u_if.ext_address_i = 32'h200;
        reset_i = 1'b1;
        next_cycle();
        u_if.ext_valid_i = 1'b0; u_if.ext_req_i = 1'b0; cpu_halt_i = 1'b1;
        #1;
        chk("mr_gnt", {31'b0, u_if.ext_gnt_o}, 32'd0);
        chk("mr_rvalid", {31'b0, u_if.ext_rvalid_o}, 32'd0);
        chk("mr_halt1", {31'b0, cpu_halt_o}, 32'd1);
        chk("mr_addr", bus_address_o, 32'h300);
        chk("mr_weram", {28'b0, bus_we_ram_o}, 32'hF);
        cpu_halt_i = 1'b0;
        #1 chk("mr_halt0", {31'b0, cpu_halt_o}, 32'd0);
        reset_i = 1'b0;
        next_cycle();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
